// File: rtl/timer_pkg.sv
// timer_pkg
// Shared types and constants for the MM:SS countdown core.
//   state_t      : controller states (IDLE, ENTRY, RUN, PAUSE, DONE)
//   bcd_t        : one BCD digit
//   BCD_NINE     : wrap value for units and minute digits
//   SEC_TENS_MAX : wrap value for the seconds-tens digit
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE     = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
// One BCD digit of the countdown chain. A load overrides everything else;
// otherwise a borrow-in decrements the digit, wrapping 0 -> WRAP.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   i_load         : load i_loadVal this cycle
//   i_loadVal      : value to load
//   i_borrowIn     : decrement request from the less significant digit
//   o_q            : registered digit value
//   o_borrowOut    : decrement request to the next digit (wrapping from 0)
//   o_zero         : digit currently holds 0
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t WRAP = BCD_NINE
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  bcd_t i_loadVal,
  input  logic i_borrowIn,
  output bcd_t o_q,
  output logic o_borrowOut,
  output logic o_zero
);

  bcd_t r_q;

  // Digit register; entered values above WRAP (e.g. tens of 6..9) just
  // count down normally until they pass through 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_loadVal;
    end else if (i_borrowIn) begin
      r_q <= (r_q == 4'd0) ? WRAP : r_q - 4'd1;
    end
  end

  assign o_q         = r_q;
  assign o_zero      = (r_q == 4'd0);
  assign o_borrowOut = i_borrowIn & o_zero;

endmodule

// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss
// MM:SS countdown core: keypad left-shift entry, start/pause/cancel control
// with a door interlock, one-second prescaler and a one-cycle done pulse.
// Optional feature macro: TIMER_ADD30_EN (adds the add30 strobe input).
// Parameters:
//   MIN_DIGITS : number of BCD minute digits (1..3)
//   TICK_DIV   : clock cycles per one-second tick (>= 2)
// Ports:
//   clock, reset             : system clock, synchronous active-high reset
//   digit_in, digit_valid    : keypad digit and its strobe (values > 9 ignored)
//   start, pause             : one-cycle control strobes
//   door_open                : door interlock level
//   add30                    : +30 s strobe (TIMER_ADD30_EN only)
//   sec_unidade, sec_decimal : seconds units / tens (BCD)
//   min                      : minute digits, least significant in [3:0]
//   zero                     : all digits are 0 (combinational)
//   running                  : controller is in RUN
//   done                     : one-cycle pulse when RUN reaches 00:00
module countdown_timer_mmss
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    door_open,
`ifdef TIMER_ADD30_EN
  input  logic                    add30,
`endif
  output logic [3:0]              sec_unidade,
  output logic [3:0]              sec_decimal,
  output logic [4*MIN_DIGITS-1:0] min,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int ND = 2 + MIN_DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  state_t          r_state;
  logic [PW-1:0]   r_prescale;
  logic            r_running;
  logic            r_done;

  bcd_t            w_q [ND];
  bcd_t            w_loadVal [ND];
  logic            w_load;
  logic [ND-1:0]   w_borrow;
  logic [ND-1:0]   w_borrowIn;
  logic [ND-1:0]   w_zeroFlag;
  logic            w_zero;
  logic            w_lastSec;
  logic            w_tick;
  logic            w_finish;
  logic            w_doDoor;
  logic            w_doPause;
  logic            w_doStart;
  logic            w_doAdd;
  logic            w_doDigit;

  // Digit chain: index 0 = seconds units, 1 = seconds tens, 2.. = minutes.
  for (genvar gi = 0; gi < ND; gi++) begin : g_digit
    bcd_down_digit #(
      .WRAP((gi == 1) ? SEC_TENS_MAX : BCD_NINE)
    ) u_digit (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_load),
      .i_loadVal  (w_loadVal[gi]),
      .i_borrowIn (w_borrowIn[gi]),
      .o_q        (w_q[gi]),
      .o_borrowOut(w_borrow[gi]),
      .o_zero     (w_zeroFlag[gi])
    );
  end

  assign w_borrowIn = {w_borrow[ND-2:0], w_tick};
  assign w_zero     = &w_zeroFlag;
  assign w_lastSec  = (w_q[0] == 4'd1) && (&w_zeroFlag[ND-1:1]);

  // Only the highest-priority asserted strobe may act. The door only takes
  // precedence while running; in other states it just blocks start.
  always_comb begin
    w_doDoor  = 1'b0;
    w_doPause = 1'b0;
    w_doStart = 1'b0;
    w_doAdd   = 1'b0;
    w_doDigit = 1'b0;
    if (door_open && r_state == RUN) begin
      w_doDoor = 1'b1;
    end else if (pause) begin
      w_doPause = (r_state != IDLE);
    end else if (start) begin
      w_doStart = (r_state == ENTRY || r_state == PAUSE) && !w_zero && !door_open;
`ifdef TIMER_ADD30_EN
    end else if (add30) begin
      w_doAdd = (r_state == RUN || r_state == PAUSE) || w_zero;
`endif
    end else if (digit_valid) begin
      w_doDigit = (digit_in <= BCD_NINE) &&
                  (r_state == IDLE || r_state == ENTRY || r_state == DONE);
    end
  end

  // A pause, door event or add30 in the tick cycle suppresses that decrement.
  assign w_tick   = (r_state == RUN) && (r_prescale == PS_LAST) &&
                    !w_doDoor && !w_doPause && !w_doAdd;
  // The top borrow can only fire if 00:00 were ever decremented; treat it as
  // completion too so the controller never keeps running on a wrapped value.
  assign w_finish = w_tick && (w_lastSec || w_borrow[ND-1]);

`ifdef TIMER_ADD30_EN
  bcd_t w_addVal [ND];
  bcd_t w_tens;
  logic w_carry;

  // +30 s: tens += 3 with a mod-6 carry into the minute chain; a carry out
  // of the top minute saturates the display at the maximum value.
  always_comb begin
    w_tens  = '0;
    w_carry = 1'b0;
    for (int i = 0; i < ND; i++) w_addVal[i] = '0;
    if (r_state == RUN || r_state == PAUSE) begin
      for (int i = 0; i < ND; i++) w_addVal[i] = w_q[i];
      w_tens = w_q[1] + 4'd3;
      if (w_tens > SEC_TENS_MAX) begin
        w_tens  = w_tens - 4'd6;
        w_carry = 1'b1;
      end
      w_addVal[1] = w_tens;
      for (int i = 2; i < ND; i++) begin
        if (w_carry) begin
          if (w_q[i] >= BCD_NINE) begin
            w_addVal[i] = '0;
          end else begin
            w_addVal[i] = w_q[i] + 4'd1;
            w_carry     = 1'b0;
          end
        end
      end
      if (w_carry) begin
        w_addVal[0] = BCD_NINE;
        w_addVal[1] = SEC_TENS_MAX;
        for (int i = 2; i < ND; i++) w_addVal[i] = BCD_NINE;
      end
    end else begin
      w_addVal[1] = 4'd3;
    end
  end
`endif

  // Load mux shared by every digit: cancel clears, entry shifts left.
  always_comb begin
    w_load = 1'b0;
    for (int i = 0; i < ND; i++) w_loadVal[i] = '0;
    if (w_doPause && r_state != RUN) begin
      w_load = 1'b1;
    end else if (w_doDigit) begin
      w_load       = 1'b1;
      w_loadVal[0] = digit_in;
      for (int i = 1; i < ND; i++) w_loadVal[i] = w_q[i-1];
`ifdef TIMER_ADD30_EN
    end else if (w_doAdd) begin
      w_load = 1'b1;
      for (int i = 0; i < ND; i++) w_loadVal[i] = w_addVal[i];
`endif
    end
  end

  // Controller, prescaler and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prescale <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == RUN) begin
        r_prescale <= (r_prescale == PS_LAST) ? '0 : r_prescale + 1'b1;
      end
      if (w_doDoor) begin
        r_state   <= PAUSE;
        r_running <= 1'b0;
      end else if (w_doPause) begin
        r_state   <= (r_state == RUN) ? PAUSE : IDLE;
        r_running <= 1'b0;
      end else if (w_doStart) begin
        r_state    <= RUN;
        r_running  <= 1'b1;
        r_prescale <= '0;
      end else if (w_doAdd) begin
        if (r_state != RUN && r_state != PAUSE) begin
          r_state    <= RUN;
          r_running  <= 1'b1;
          r_prescale <= '0;
        end
      end else if (w_doDigit) begin
        r_state <= ENTRY;
      end else if (w_finish) begin
        r_state   <= DONE;
        r_running <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  assign sec_unidade = w_q[0];
  assign sec_decimal = w_q[1];
  for (genvar gm = 0; gm < MIN_DIGITS; gm++) begin : g_min
    assign min[4*gm +: 4] = w_q[gm+2];
  end
  assign zero    = w_zero;
  assign running = r_running;
  assign done    = r_done;

endmodule
